// File: rtl/fpaddsub_pkg.sv
// Shared types and constants for the FP add/sub arbiter slice.
package fpaddsub_pkg;

  localparam int FP_W        = 32;
  localparam int RES_W       = FP_W + 1;
  localparam int CRED_W      = 4;
  localparam int DEF_LATENCY = 4;
  localparam int DEF_RBUF    = 4;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    vld;
    req_id_e owner;
  } tag_t;

  // A grant consumes a credit and a pop returns one; both together cancel.
  function automatic logic [CRED_W-1:0] cred_update(logic [CRED_W-1:0] c, logic dec, logic inc);
    if (dec && !inc) return c - 1'b1;
    if (inc && !dec) return c + 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/fpaddsub_arbiter_if.sv
// Requester, datapath and result signals of the shared FP add/sub arbiter.
interface fpaddsub_arbiter_if;
  import fpaddsub_pkg::*;

  logic            a_valid, b_valid;
  logic            a_ready, b_ready;
  logic [FP_W-1:0] a_opa, a_opb, b_opa, b_opb;
  logic            a_ctrl, b_ctrl;

  logic            dp_issue;
  logic [FP_W-1:0] dp_opa, dp_opb;
  logic            dp_ctrl;
  logic [FP_W-1:0] dp_z;
  logic            dp_eof;

  logic            a_rvalid, b_rvalid;
  logic            a_rready, b_rready;
  logic [FP_W-1:0] a_z, b_z;
  logic            a_eof, b_eof;

  modport slave (
    input  a_valid, b_valid, a_opa, a_opb, b_opa, b_opb, a_ctrl, b_ctrl,
    input  dp_z, dp_eof, a_rready, b_rready,
    output a_ready, b_ready, dp_issue, dp_opa, dp_opb, dp_ctrl,
    output a_rvalid, b_rvalid, a_z, b_z, a_eof, b_eof
  );

  modport master (
    output a_valid, b_valid, a_opa, a_opb, b_opa, b_opb, a_ctrl, b_ctrl,
    output dp_z, dp_eof, a_rready, b_rready,
    input  a_ready, b_ready, dp_issue, dp_opa, dp_opb, dp_ctrl,
    input  a_rvalid, b_rvalid, a_z, b_z, a_eof, b_eof
  );

endinterface

// File: rtl/fpaddsub_result_fifo.sv
// First-word-fall-through result FIFO; head data reads as zero while empty.
module fpaddsub_result_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop = pop_i && (cnt_q != '0);
    wptr_d = push_i ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_pop ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    if (push_i && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_i && do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign empty_o = (cnt_q == '0);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/fpaddsub_arbiter.sv
// Round-robin issue of two requesters into a fixed-latency FP add/sub datapath,
// with owner tags steering each result into a credit-protected per-requester FIFO.
module fpaddsub_arbiter
  import fpaddsub_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int RBUF    = DEF_RBUF
) (
  input logic               clk,
  input logic               rst,
  fpaddsub_arbiter_if.slave bus
);

  localparam logic [CRED_W-1:0] CRED_INIT = CRED_W'(RBUF);

  logic [CRED_W-1:0] cred_a_q, cred_a_d, cred_b_q, cred_b_d;
  req_id_e           last_q, last_d;
  tag_t              tag_q [LATENCY];

  logic             elig_a, elig_b, grant_a, grant_b, issue;
  logic             pop_a, pop_b, push_a, push_b;
  logic             empty_a, empty_b;
  logic [RES_W-1:0] head_a, head_b, res_w;

  // Grants are held off during reset so ready reads low while rst is high.
  always_comb begin
    elig_a  = bus.a_valid && (cred_a_q != '0) && !rst;
    elig_b  = bus.b_valid && (cred_b_q != '0) && !rst;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (elig_a && elig_b) begin
      if (last_q == REQ_A) grant_b = 1'b1;
      else                 grant_a = 1'b1;
    end else if (elig_a) begin
      grant_a = 1'b1;
    end else if (elig_b) begin
      grant_b = 1'b1;
    end
    issue = grant_a || grant_b;
  end

  always_comb begin
    bus.dp_opa  = '0;
    bus.dp_opb  = '0;
    bus.dp_ctrl = 1'b0;
    if (grant_a) begin
      bus.dp_opa  = bus.a_opa;
      bus.dp_opb  = bus.a_opb;
      bus.dp_ctrl = bus.a_ctrl;
    end else if (grant_b) begin
      bus.dp_opa  = bus.b_opa;
      bus.dp_opb  = bus.b_opb;
      bus.dp_ctrl = bus.b_ctrl;
    end
  end

  assign bus.a_ready  = grant_a;
  assign bus.b_ready  = grant_b;
  assign bus.dp_issue = issue;

  always_comb begin
    pop_a    = !empty_a && bus.a_rready;
    pop_b    = !empty_b && bus.b_rready;
    cred_a_d = cred_update(cred_a_q, grant_a, pop_a);
    cred_b_d = cred_update(cred_b_q, grant_b, pop_b);
    last_d   = last_q;
    if (grant_a)      last_d = REQ_A;
    else if (grant_b) last_d = REQ_B;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cred_a_q <= CRED_INIT;
      cred_b_q <= CRED_INIT;
      last_q   <= REQ_B;
    end else begin
      cred_a_q <= cred_a_d;
      cred_b_q <= cred_b_d;
      last_q   <= last_d;
    end
  end

  // Tag shift register runs in lockstep with the datapath stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: issue, owner: (grant_b ? REQ_B : REQ_A)};
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign res_w  = {bus.dp_eof, bus.dp_z};
  assign push_a = tag_q[LATENCY-1].vld && (tag_q[LATENCY-1].owner == REQ_A);
  assign push_b = tag_q[LATENCY-1].vld && (tag_q[LATENCY-1].owner == REQ_B);

  fpaddsub_result_fifo #(.W(RES_W), .DEPTH(RBUF)) u_fifo_a (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_a),
    .wdata_i (res_w),
    .pop_i   (pop_a),
    .rdata_o (head_a),
    .empty_o (empty_a)
  );

  fpaddsub_result_fifo #(.W(RES_W), .DEPTH(RBUF)) u_fifo_b (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_b),
    .wdata_i (res_w),
    .pop_i   (pop_b),
    .rdata_o (head_b),
    .empty_o (empty_b)
  );

  assign bus.a_rvalid = !empty_a;
  assign bus.b_rvalid = !empty_b;
  assign bus.a_z      = head_a[FP_W-1:0];
  assign bus.a_eof    = head_a[FP_W];
  assign bus.b_z      = head_b[FP_W-1:0];
  assign bus.b_eof    = head_b[FP_W];

endmodule

// File: tb/tb_fpaddsub_arbiter.sv
// Bench for fpaddsub_arbiter: behavioural FP datapath plus per-requester scoreboards.
module tb_fpaddsub_arbiter;
  import fpaddsub_pkg::*;

  localparam int LATENCY = 4;
  localparam int RBUF    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpaddsub_arbiter_if bus();

  fpaddsub_arbiter #(.LATENCY(LATENCY), .RBUF(RBUF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [32:0] a_exp, b_exp;

  typedef struct {
    logic        id;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        ctrl;
    logic [31:0] z;
    logic        eof;
  } vec_t;
  vec_t vecs[8];

  function automatic real sp2real(input logic [31:0] b);
    logic [63:0] d;
    int e;
    if (b[30:23] == 8'd0) return 0.0;
    e = int'(b[30:23]) - 127 + 1023;
    d = {b[31], 11'(e), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Truncating double-to-single; returns {eof, z}.
  function automatic logic [32:0] real2sp(input real r);
    logic [63:0] d;
    int e;
    if (r == 0.0) return 33'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, d[63], 31'd0};
    return {1'b0, d[63], 8'(e), d[51:29]};
  endfunction

  function automatic logic [32:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic c);
    real ra, rb;
    ra = sp2real(a);
    rb = sp2real(b);
    return real2sp(c ? (ra - rb) : (ra + rb));
  endfunction

  logic [32:0] dp_pipe [LATENCY];
  always @(posedge clk) begin
    dp_pipe[0] <= bus.dp_issue ? fp_model(bus.dp_opa, bus.dp_opb, bus.dp_ctrl) : 33'd0;
    for (int i = 1; i < LATENCY; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign bus.dp_z   = dp_pipe[LATENCY-1][31:0];
  assign bus.dp_eof = dp_pipe[LATENCY-1][32];

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb();
    logic [32:0] e;
    if (rst) begin
      qa.delete();
      qb.delete();
      return;
    end
    if (bus.a_valid && bus.a_ready) qa.push_back(a_exp);
    if (bus.b_valid && bus.b_ready) qb.push_back(b_exp);
    if (dut.push_a && int'(dut.u_fifo_a.cnt_q) == RBUF) begin
      checks++; errors++;
      $display("FAIL fifo_a_overflow: got push into full FIFO expected none");
    end
    if (dut.push_b && int'(dut.u_fifo_b.cnt_q) == RBUF) begin
      checks++; errors++;
      $display("FAIL fifo_b_overflow: got push into full FIFO expected none");
    end
    if (bus.a_rvalid) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got rvalid=1 expected rvalid=0");
      end else if (bus.a_rready) begin
        e = qa.pop_front();
        chk_w("a_result", {bus.a_eof, bus.a_z}, e);
      end
    end
    if (bus.b_rvalid) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got rvalid=1 expected rvalid=0");
      end else if (bus.b_rready) begin
        e = qb.pop_front();
        chk_w("b_result", {bus.b_eof, bus.b_z}, e);
      end
    end
  endtask

  // Inputs change at posedge+1; sampling and scoreboarding happen at negedge.
  task automatic cyc();
    @(negedge clk);
    sb();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_a(input int n);
    logic [32:0] t;
    t = real2sp(real'(n + 1));
    bus.a_opa = t[31:0];
    t = real2sp(2.0);
    bus.a_opb = t[31:0];
    bus.a_ctrl = n[0];
    a_exp = fp_model(bus.a_opa, bus.a_opb, bus.a_ctrl);
  endtask

  task automatic set_b(input int n);
    logic [32:0] t;
    t = real2sp(100.0 + real'(n));
    bus.b_opa = t[31:0];
    t = real2sp(0.5);
    bus.b_opb = t[31:0];
    bus.b_ctrl = 1'b0;
    b_exp = fp_model(bus.b_opa, bus.b_opb, bus.b_ctrl);
  endtask

  task automatic drive_one(input vec_t v);
    int n;
    logic rdy;
    n = 0;
    if (v.id == 1'b0) begin
      bus.a_opa = v.opa; bus.a_opb = v.opb; bus.a_ctrl = v.ctrl;
      a_exp = {v.eof, v.z}; bus.a_valid = 1'b1;
    end else begin
      bus.b_opa = v.opa; bus.b_opb = v.opb; bus.b_ctrl = v.ctrl;
      b_exp = {v.eof, v.z}; bus.b_valid = 1'b1;
    end
    #1;
    rdy = v.id ? bus.b_ready : bus.a_ready;
    while (!rdy && n < 20) begin
      cyc();
      #1;
      n++;
      rdy = v.id ? bus.b_ready : bus.a_ready;
    end
    chk_b("tbl_ready", rdy, 1'b1);
    cyc();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.a_rready = 1'b1;
    bus.b_rready = 1'b1;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      cyc();
      n++;
    end
    chk_i("drain_pending", qa.size() + qb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb;
    logic ga, gb;

    vecs[0] = '{1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0};
    vecs[1] = '{1'b1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0};
    vecs[2] = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1};
    vecs[3] = '{1'b1, 32'h40A00000, 32'h40A00000, 1'b0, 32'h41200000, 1'b0};
    vecs[4] = '{1'b0, 32'h41200000, 32'h40000000, 1'b1, 32'h41000000, 1'b0};
    vecs[5] = '{1'b1, 32'h3F000000, 32'h3F000000, 1'b0, 32'h3F800000, 1'b0};
    vecs[6] = '{1'b0, 32'h42280000, 32'h41200000, 1'b1, 32'h42000000, 1'b0};
    vecs[7] = '{1'b1, 32'h40800000, 32'h40400000, 1'b0, 32'h40E00000, 1'b0};

    bus.a_opa = '0; bus.a_opb = '0; bus.a_ctrl = 1'b0;
    bus.b_opa = '0; bus.b_opb = '0; bus.b_ctrl = 1'b0;
    bus.a_rready = 1'b0; bus.b_rready = 1'b0;
    a_exp = '0; b_exp = '0;
    do_reset();
    #1;
    chk_b("rst_a_ready", bus.a_ready, 1'b0);
    chk_b("rst_b_ready", bus.b_ready, 1'b0);
    chk_b("rst_dp_issue", bus.dp_issue, 1'b0);
    chk_b("rst_a_rvalid", bus.a_rvalid, 1'b0);
    chk_b("rst_b_rvalid", bus.b_rvalid, 1'b0);
    chk_b("rst_dp_ctrl", bus.dp_ctrl, 1'b0);
    chk_b("rst_a_eof", bus.a_eof, 1'b0);
    chk_b("rst_b_eof", bus.b_eof, 1'b0);
    chk_w("rst_a_z", {1'b0, bus.a_z}, 33'd0);
    chk_w("rst_b_z", {1'b0, bus.b_z}, 33'd0);
    chk_w("rst_dp_opa", {1'b0, bus.dp_opa}, 33'd0);
    chk_w("rst_dp_opb", {1'b0, bus.dp_opb}, 33'd0);

    // Single op: result visible exactly LATENCY edges after the accept edge.
    bus.a_rready = 1'b1;
    bus.b_rready = 1'b1;
    bus.a_opa = 32'h3F800000; bus.a_opb = 32'h40000000; bus.a_ctrl = 1'b0;
    a_exp = {1'b0, 32'h40400000};
    bus.a_valid = 1'b1;
    #1;
    chk_b("single_ready", bus.a_ready, 1'b1);
    chk_w("single_dp_opa", {1'b0, bus.dp_opa}, {1'b0, 32'h3F800000});
    cyc();
    bus.a_valid = 1'b0;
    for (int j = 0; j <= LATENCY; j++) begin
      chk_b("single_a_rvalid", bus.a_rvalid, (j == LATENCY));
      chk_b("single_b_rvalid", bus.b_rvalid, 1'b0);
      cyc();
    end
    drain();

    for (int i = 0; i < 8; i++) drive_one(vecs[i]);
    drain();

    // Contention: both valid straight out of reset alternate A,B,...
    do_reset();
    bus.a_rready = 1'b1; bus.b_rready = 1'b1;
    na = 0; nb = 0;
    set_a(0); set_b(0);
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk_b("cont_a_ready", bus.a_ready, (i % 2 == 0));
      chk_b("cont_b_ready", bus.b_ready, (i % 2 == 1));
      ga = bus.a_ready; gb = bus.b_ready;
      cyc();
      if (ga) begin na++; set_a(na); end
      if (gb) begin nb++; set_b(nb); end
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    chk_i("cont_a_count", na, 3);
    chk_i("cont_b_count", nb, 3);
    drain();

    // Back-pressure: A never pops, so it stalls after RBUF accepts.
    do_reset();
    bus.a_rready = 1'b0; bus.b_rready = 1'b1;
    na = 0; nb = 0;
    set_a(0); set_b(0);
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (k >= 8) chk_b("bp_a_blocked", bus.a_ready, 1'b0);
      ga = bus.a_ready; gb = bus.b_ready;
      cyc();
      if (ga) begin na++; set_a(na); end
      if (gb) begin nb++; set_b(nb); end
    end
    chk_i("bp_a_accepts", na, RBUF);
    chk_i("bp_cred_a", int'(dut.cred_a_q), 0);
    chk_b("bp_b_progress", (nb > 4), 1'b1);
    bus.b_valid = 1'b0;
    bus.a_rready = 1'b1;
    #1;
    chk_b("bp_pre_pop_ready", bus.a_ready, 1'b0);
    cyc();
    bus.a_rready = 1'b0;
    #1;
    chk_b("bp_reenable", bus.a_ready, 1'b1);
    cyc();
    bus.a_valid = 1'b0;
    for (int k = 0; k < LATENCY + 2; k++) cyc();
    chk_i("bp_cred_a_empty", int'(dut.cred_a_q), 0);

    // Pop and issue in the same cycle with one credit left.
    bus.a_rready = 1'b1;
    cyc();
    set_a(7);
    bus.a_valid = 1'b1;
    #1;
    chk_b("sim_ready", bus.a_ready, 1'b1);
    chk_b("sim_rvalid", bus.a_rvalid, 1'b1);
    cyc();
    bus.a_valid = 1'b0;
    chk_i("sim_cred_a", int'(dut.cred_a_q), 1);
    drain();
    chk_i("sim_cred_a_restored", int'(dut.cred_a_q), RBUF);

    // Reset with three ops in flight: none of them may surface.
    bus.a_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_a(i);
      bus.a_valid = 1'b1;
      #1;
      chk_b("mf_ready", bus.a_ready, 1'b1);
      cyc();
    end
    bus.a_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int j = 0; j < LATENCY + 4; j++) begin
      chk_b("mf_no_rvalid", bus.a_rvalid, 1'b0);
      cyc();
    end
    chk_i("mf_cred_a", int'(dut.cred_a_q), RBUF);
    chk_i("mf_cred_b", int'(dut.cred_b_q), RBUF);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpaddsub_arbiter.md
# fpaddsub_arbiter

Shares one pipelined single-precision FP add/sub datapath between two requesters, A and B. The block owns issue into the datapath, whose last stage is the rounding stage that produces Z and EOF. It does round-robin arbitration on valid/ready request ports and tracks which requester owns each in-flight operation. It routes every result, with its exponent-overflow flag, into a per-requester result FIFO. Credit counters guarantee a result FIFO never overflows, so the datapath never needs to stall.

## Interface
- LATENCY, 4, fixed datapath latency in cycles from issue to valid dp_z/dp_eof (1..8)
- RBUF, 4, result FIFO depth per requester, which is also the initial credit count (1..15)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- a_valid, b_valid  in  1  request present
- a_ready, b_ready  out  1  request accepted this cycle when valid&ready
- a_opa, a_opb, b_opa, b_opb  in  32  IEEE-754 single operands
- a_ctrl, b_ctrl  in  1  operation: 0 = add, 1 = subtract
- dp_issue  out  1  operation launched into datapath this cycle
- dp_opa, dp_opb  out  32  operands of granted requester
- dp_ctrl  out  1  operation of granted requester
- dp_z  in  32  datapath result, valid LATENCY cycles after its dp_issue
- dp_eof  in  1  exponent overflow from rounding stage, same timing as dp_z
- a_rvalid, b_rvalid  out  1  result available at FIFO head
- a_rready, b_rready  in  1  consumer pops result when rvalid&rready
- a_z, b_z  out  32  result at FIFO head
- a_eof, b_eof  out  1  EOF flag stored with that result

## Operation
- Credits: credA and credB, 4 bits each, reset to RBUF.
  - −1 on a grant to that requester; +1 on a pop from its FIFO.
  - Grant and pop in the same cycle leave the count unchanged.
- Eligibility: eligX = x_valid & (credX != 0).
- Round-robin pointer `last` (1 bit, 0 = A, 1 = B) records the last granted requester. Reset value is B, so A wins the first contention.
- Grant: if both eligible, grant the one ≠ last; otherwise grant the single eligible one; otherwise no grant.
  - `last` updates only on a grant.
  - At most one grant per cycle.
- x_ready = grant to X. It is combinational from valid, credits and `last`.
- dp_issue = (a_ready|b_ready).
  - dp_opa/dp_opb/dp_ctrl mux the granted requester's operands.
  - They are driven 0 when idle.
- Tag pipeline: LATENCY-stage shift register of {vld, owner}. Stage 0 is loaded with {dp_issue, granted id}.
- On the output stage with vld=1, {dp_z, dp_eof} is pushed into the owner's FIFO. Results with vld=0 are ignored.
- FIFOs are first-word-fall-through: x_rvalid = FIFO non-empty; x_z/x_eof show the head entry.
  - A push and a pop in the same cycle are both honoured.
  - Push into a full FIFO is impossible by construction. The bench asserts against it.
- Ordering: results per requester return in issue order. There is no ordering between A and B.

## Timing
- Reset values:
  - a_ready = b_ready = dp_issue = 0.
  - a_rvalid = b_rvalid = 0.
  - a_z, b_z, dp_opa, dp_opb = 0; dp_ctrl, a_eof, b_eof = 0.
- Reset flush: all tag vld bits, FIFOs and credits are cleared or restored. Datapath results from pre-reset issues are dropped.
- Latency:
  - An accept at edge t is issued in cycle t.
  - Its result is pushed at edge t+LATENCY.
  - x_rvalid rises in cycle t+LATENCY+1, so request to result is LATENCY+1 cycles.
- Throughput: one issue per cycle total. With both requesters eligible, grants alternate A, B, A, B.
- Full back-pressure: RBUF consecutive issues to X with x_rready=0 leave credX=0 and drop x_ready. A pop re-enables x_ready in the next cycle.

## Structure
- Shared package fpaddsub_pkg:
  - FP_W = 32.
  - Requester-id type: REQ_A = 0, REQ_B = 1.
  - Default LATENCY.
- Sub-module fpaddsub_result_fifo:
  - Parameterised FWFT FIFO, width 33 ({eof, z}), depth RBUF, synchronous reset.
  - Instantiated twice.
- Arbiter, credits and tag pipeline live in the top module.

## Test plan
- Single op: A issues 0x3F800000 + 0x40000000 with ctrl=0 at cycle 1 → a_rvalid in cycle LATENCY+2 with a_z=0x40400000 and a_eof=0; b_rvalid stays 0.
- Contention: both valid for 6 cycles after reset → grant order A,B,A,B,A,B; each FIFO receives 3 results in issue order.
- Back-pressure: A streams with a_rready=0 and RBUF=4 → exactly 4 accepts, then a_ready=0 while B is still granted. One pop → a_ready=1 the next cycle.
- Overflow flag: A issues 0x7F7FFFFF + 0x7F7FFFFF → a_eof=1 arrives with that result, and no other result is affected.
- Simultaneous pop+issue at credA=1 → credA stays 1 and no FIFO overflow assertion fires.
- Reset mid-flight: rst for 1 cycle with 3 ops outstanding → no rvalid afterwards for those ops, and credits read RBUF.
